// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg: shared CPU widths, PC step and fetch entry type          |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package cpu_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Sequential successor address; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_skid_buffer: one-entry holding slot for the in-flight word  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module fetch_skid_buffer
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         capture,
    input  logic         drain,
    input  logic         flush,
    input  fetch_entry_t in_entry,
    output logic         full,
    output fetch_entry_t out_entry
);

    // Flush beats capture so a redirect never leaves a stale word behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= 1'b0;
            out_entry <= '0;
        end else if (flush) begin
            full      <= 1'b0;
        end else if (capture) begin
            full      <= 1'b1;
            out_entry <= in_entry;
        end else if (drain) begin
            full      <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_stage: pipelined instruction fetch with stall skid/redirect |
// | Optional perf counters when FETCH_PERF_EN is defined.             |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_in,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_flush_count
`endif
);

    logic [ADDR_W-1:0] pc_q;
    logic              resp_valid_q;
    logic [ADDR_W-1:0] resp_pc_q;

    logic              stalled;
    logic              issue;
    logic              out_load;
    logic              skid_capture;
    logic              skid_drain;
    logic              skid_full;
    fetch_entry_t      resp_entry;
    fetch_entry_t      skid_entry;
    logic [ADDR_W-1:0] skid_pc;

    always_comb begin
        stalled      = stall_in && if_valid;
        issue        = !stalled && !redirect_valid;
        out_load     = !if_valid || !stall_in;
        skid_capture = stalled && resp_valid_q;
        skid_drain   = out_load && skid_full;
        resp_entry   = '{instr: imem_rdata, pc: resp_pc_q};
    end

    assign imem_addr   = pc_q;
    assign if_pc_plus4 = next_pc(if_pc);
    assign skid_pc     = skid_entry.pc;

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .rst       (reset),
        .capture   (skid_capture),
        .drain     (skid_drain),
        .flush     (redirect_valid),
        .in_entry  (resp_entry),
        .full      (skid_full),
        .out_entry (skid_entry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
            if_valid     <= 1'b0;
            if_instr     <= '0;
            if_pc        <= '0;
        end else if (redirect_valid) begin
            pc_q         <= redirect_pc;
            resp_valid_q <= 1'b0;
            if_valid     <= 1'b0;
        end else begin
            resp_valid_q <= issue;
            if (issue) begin
                resp_pc_q <= pc_q;
                pc_q      <= next_pc(pc_q);
            end
            // Skid holds the older word, so it always drains ahead of the response.
            if (out_load) begin
                if (skid_full) begin
                    if_valid <= 1'b1;
                    if_instr <= skid_entry.instr;
                    if_pc    <= skid_pc;
                end else if (resp_valid_q) begin
                    if_valid <= 1'b1;
                    if_instr <= imem_rdata;
                    if_pc    <= resp_pc_q;
                end else begin
                    if_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (stalled)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (redirect_valid)
                perf_flush_count  <= perf_flush_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
